// File: rtl/fir_serial_mac.sv
// fir_serial_mac: parametrised FIR filter built around one time-multiplexed MAC.
// One tap is processed per clock, so a sample takes TAPS MAC cycles plus one
// output cycle. Coefficients are writable at run time while the block is idle.
// Optional build macro: FIR_SATURATE_EN clamps the output instead of wrapping.
module fir_serial_mac #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int TAPS      = 8,
    parameter int OUT_SHIFT = 15
) (
    input  logic                    system1000,
    input  logic                    system1000_rstn,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]       coef_data,
    output logic                    busy
);

    // Derived widths; the accumulator is sized so TAPS full products never overflow.
    localparam int AW    = $clog2(TAPS);
    localparam int P_W   = DATA_W + COEF_W;
    localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);

    // Reset value of c[0]: +1.0 saturated to the largest positive coefficient.
    localparam logic signed [COEF_W-1:0] C0_RST = {1'b0, {(COEF_W-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                   state;
    logic signed [DATA_W-1:0] x [TAPS];
    logic signed [COEF_W-1:0] c [TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic [AW-1:0]            idx;

    logic signed [DATA_W-1:0] x_sel;
    logic signed [COEF_W-1:0] c_sel;
    logic signed [P_W-1:0]    x_ext;
    logic signed [P_W-1:0]    c_ext;
    logic signed [P_W-1:0]    prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_sum;
    logic [DATA_W-1:0]        y;

    // Single shared multiplier: operands are sign-extended to the full product width
    // so the low P_W bits of the multiply are the exact signed product.
    assign x_sel    = x[idx];
    assign c_sel    = c[idx];
    assign x_ext    = {{COEF_W{x_sel[DATA_W-1]}}, x_sel};
    assign c_ext    = {{DATA_W{c_sel[COEF_W-1]}}, c_sel};
    assign prod     = x_ext * c_ext;
    assign prod_ext = {{(ACC_W-P_W){prod[P_W-1]}}, prod};
    assign acc_sum  = acc + prod_ext;

`ifdef FIR_SATURATE_EN
    localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] shifted;
    assign shifted = acc_sum >>> OUT_SHIFT;

    // Clamp the scaled accumulator into the signed output range.
    // NOTE: y gets a default first so no path through this block can infer a latch.
    always_comb begin
        y = shifted[DATA_W-1:0];
        if (shifted > Y_MAX) begin
            y = Y_MAX[DATA_W-1:0];
        end else if (shifted < Y_MIN) begin
            y = Y_MIN[DATA_W-1:0];
        end
    end
`else
    // Two's-complement wrap: keep only the low DATA_W bits of the scaled accumulator.
    assign y = DATA_W'(acc_sum >>> OUT_SHIFT);
`endif

    // Control FSM, delay line, coefficient bank and MAC accumulator.
    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            acc       <= '0;
            idx       <= '0;
            // NOTE: the small delay line and coefficient bank are flops, so they are reset
            // here; a reset mid-computation must restore the passthrough coefficients.
            for (int i = 0; i < TAPS; i++) begin
                x[i] <= '0;
                c[i] <= (i == 0) ? C0_RST : '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // A write in the same cycle as an accept lands before the MAC reads c[].
                    if (coef_we && (int'(coef_addr) < TAPS)) begin
                        c[coef_addr] <= coef_data;
                    end
                    if (in_valid) begin
                        x[0] <= in_data;
                        for (int i = 1; i < TAPS; i++) begin
                            x[i] <= x[i-1];
                        end
                        acc      <= '0;
                        idx      <= '0;
                        state    <= MAC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                MAC: begin
                    acc <= acc_sum;
                    idx <= idx + 1'b1;
                    // The last tap's sum goes straight to the output register.
                    if (idx == AW'(TAPS - 1)) begin
                        out_data  <= y;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_serial_mac.sv
// tb_fir_serial_mac: directed self-checking bench for fir_serial_mac at default
// parameters. Expected outputs are hand-computed; define FIR_SATURATE_EN for both
// the DUT and this bench to check the clamping build.
module tb_fir_serial_mac;

    logic              system1000      = 1'b0;
    logic              system1000_rstn = 1'b1;
    logic signed [15:0] in_data   = '0;
    logic              in_valid   = 1'b0;
    logic              in_ready;
    logic signed [15:0] out_data;
    logic              out_valid;
    logic              out_ready  = 1'b1;
    logic              coef_we    = 1'b0;
    logic [2:0]        coef_addr  = '0;
    logic [15:0]       coef_data  = '0;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;
    int last_lat;

    fir_serial_mac dut (
        .system1000      (system1000),
        .system1000_rstn (system1000_rstn),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .coef_we         (coef_we),
        .coef_addr       (coef_addr),
        .coef_data       (coef_data),
        .busy            (busy)
    );

    always #5 system1000 = ~system1000;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge system1000);
        in_valid        = 1'b0;
        coef_we         = 1'b0;
        out_ready       = 1'b1;
        system1000_rstn = 1'b0;
        @(negedge system1000);
        @(negedge system1000);
        system1000_rstn = 1'b1;
    endtask

    task automatic write_coef(input logic [2:0] a, input logic [15:0] d);
        @(negedge system1000);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d;
        @(negedge system1000);
        coef_we   = 1'b0;
    endtask

    // Present one sample in IDLE; returns at the negedge just after the accept edge.
    task automatic send(input logic signed [15:0] s);
        @(negedge system1000);
        in_data  = s;
        in_valid = 1'b1;
        @(negedge system1000);
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid and check the data; latency counted from the accept.
    task automatic recv(input string tag, input logic signed [63:0] exp);
        int cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(negedge system1000);
            cyc++;
        end
        last_lat = cyc;
        check({tag, "_valid"}, out_valid, 1);
        check(tag, out_data, exp);
    endtask

    initial begin
        int pulses;
        logic signed [63:0] sat_exp;

        // Reset state and passthrough with the saturated +1.0 coefficient.
        do_reset();
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        send(1000);
        check("mac_busy", busy, 1);
        check("mac_in_ready", in_ready, 0);
        recv("passthru", 999);
        check("latency", last_lat, 9);

        // Coefficient write and sample accept in the same IDLE cycle.
        do_reset();
        @(negedge system1000);
        coef_we   = 1'b1;
        coef_addr = 3'd0;
        coef_data = 16'h4000;
        in_data   = 1000;
        in_valid  = 1'b1;
        @(negedge system1000);
        coef_we   = 1'b0;
        in_valid  = 1'b0;
        recv("wr_accept", 500);

        // Impulse response: c[k] = (k+1)*2048, impulse of 16 gives k+1 per output.
        do_reset();
        for (int k = 0; k < 8; k++) write_coef(3'(k), 16'((k + 1) * 2048));
        send(16);
        recv("impulse", 1);
        for (int k = 1; k < 8; k++) begin
            send(0);
            recv("impulse", k + 1);
        end
        send(0);
        recv("impulse_tail", 0);

        // Full-scale input against full-scale coefficients: n*32766 after n samples.
        do_reset();
        for (int k = 0; k < 8; k++) write_coef(3'(k), 16'h7FFF);
        for (int n = 1; n <= 8; n++) begin
`ifdef FIR_SATURATE_EN
            sat_exp = (n == 1) ? 64'sd32766 : 64'sd32767;
`else
            sat_exp = (n % 2 == 1) ? 64'(32768 - 2 * n) : -64'(2 * n);
`endif
            send(32767);
            recv("saturate", sat_exp);
        end

        // Backpressure in OUT: output held, input ignored, single transfer on release.
        do_reset();
        write_coef(3'd1, 16'h4000);
        out_ready = 1'b0;
        send(1000);
        recv("bp_first", 999);
        in_data  = 5000;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge system1000);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_data", out_data, 999);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge system1000);
        check("bp_done_valid", out_valid, 0);
        check("bp_done_in_ready", in_ready, 1);
        send(0);
        recv("bp_next", 500);

        // Coefficient write during MAC is ignored.
        do_reset();
        send(1000);
        coef_we   = 1'b1;
        coef_addr = 3'd0;
        coef_data = 16'h0000;
        @(negedge system1000);
        @(negedge system1000);
        coef_we   = 1'b0;
        recv("busy_wr", 999);
        send(2000);
        recv("busy_wr_next", 1999);

        // Reset in the middle of MAC (idx = 3).
        do_reset();
        write_coef(3'd0, 16'h4000);
        send(1000);
        repeat (3) @(negedge system1000);
        check("midrst_busy_before", busy, 1);
        system1000_rstn = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        @(negedge system1000);
        system1000_rstn = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge system1000);
            if (out_valid) pulses++;
        end
        check("midrst_no_pulse", pulses, 0);
        send(1000);
        recv("midrst_next", 999);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
